// File: rtl/row_variance.sv
// Streaming population variance of one row against a supplied fixed-point mean.
// Result is registered on the last element's handshake; a held result blocks new means and elements.
module row_variance #(
   parameter int N              = 4,
   parameter int WIDTH          = 8,
   parameter int FRACTION_WIDTH = 8,
   parameter int MEAN_WIDTH     = WIDTH + $clog2(N) + FRACTION_WIDTH,
   parameter int VAR_WIDTH      = 2*WIDTH + FRACTION_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mean_valid,
   output logic                  mean_ready,
   input  logic [MEAN_WIDTH-1:0] mean_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [VAR_WIDTH-1:0]  var_out,
   output logic [MEAN_WIDTH-1:0] mean_out
);

   localparam int CNT_WIDTH = $clog2(N);
   localparam int D_WIDTH   = MEAN_WIDTH + 1;
   localparam int SQ_WIDTH  = 2*D_WIDTH;
   localparam int ACC_WIDTH = SQ_WIDTH + $clog2(N);
   localparam int PAD_WIDTH = D_WIDTH - WIDTH - FRACTION_WIDTH;

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(N-1);
   localparam logic [ACC_WIDTH-1:0] N_DIV    = ACC_WIDTH'(N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [MEAN_WIDTH-1:0] mean_q;
   logic [ACC_WIDTH-1:0]  acc;
   logic [ACC_WIDTH-1:0]  acc_nxt;
   logic [CNT_WIDTH-1:0]  cnt;

   logic [D_WIDTH-1:0]         elem_ext;
   logic signed [D_WIDTH-1:0]  dev;
   logic signed [SQ_WIDTH-1:0] dev_ext;
   logic signed [SQ_WIDTH-1:0] sq;

   logic mean_fire;
   logic elem_fire;
   logic last_elem;

   assign mean_fire = mean_valid && mean_ready;
   assign elem_fire = in_valid && in_ready;
   assign last_elem = (cnt == LAST_CNT);

   // Element lifted to the mean's Q format; deviation is exact in one extra signed bit.
   always_comb begin
      elem_ext = {{PAD_WIDTH{1'b0}}, in_data, {FRACTION_WIDTH{1'b0}}};
      dev      = $signed(elem_ext) - $signed({1'b0, mean_q});
      dev_ext  = SQ_WIDTH'(dev);
      sq       = dev_ext * dev_ext;
      acc_nxt  = acc + ACC_WIDTH'($unsigned(sq));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mean_fire) state_nxt = ACCUM;
         ACCUM:   if (elem_fire && last_elem) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mean_ready = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE:    mean_ready = 1'b1;
         ACCUM:   in_ready   = 1'b1;
         DONE:    out_valid  = 1'b1;
         default: mean_ready = 1'b0;
      endcase
   end

   // Accumulator carries 2*FRACTION_WIDTH fraction bits; divide then drop one Q factor.
   always_ff @(posedge clk) begin
      if (rst) begin
         mean_q   <= '0;
         acc      <= '0;
         cnt      <= '0;
         var_out  <= '0;
         mean_out <= '0;
      end else begin
         if (mean_fire) begin
            mean_q <= mean_in;
            acc    <= '0;
            cnt    <= '0;
         end
         if (elem_fire) begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_WIDTH'(1);
            if (last_elem) begin
               var_out  <= VAR_WIDTH'((acc_nxt / N_DIV) >> FRACTION_WIDTH);
               mean_out <= mean_q;
            end
         end
      end
   end

endmodule
